// File: rtl/output_unit_pkg.sv
// ============================================================================
// Module      : output_unit_pkg
// Description : Shared router constants for the output unit: flit and
//               direction widths, downstream credit depth, credit counter
//               width helper and link state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Router-wide defaults; a project router.vh included earlier takes precedence.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif
`ifndef DIRECTION
`define DIRECTION 5
`endif
`ifndef ROUTER_FIFO_DEPTH
`define ROUTER_FIFO_DEPTH 4
`endif
`ifndef ROUTER_FIFO_SPLIT
`define ROUTER_FIFO_SPLIT 2
`endif

package output_unit_pkg;

    // Downstream input-buffer slots available to one output port.
    localparam int c_credit_max = `ROUTER_FIFO_DEPTH * `ROUTER_FIFO_SPLIT;

    // Link state encoding: one INIT cycle after reset, then RUN forever.
    typedef logic [0:0] link_state_t;
    localparam logic [0:0] c_st_init = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    // Counter width able to hold 0..max_val inclusive.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/output_unit_credit_counter.sv
// ============================================================================
// Module      : output_unit_credit_counter
// Description : Saturating downstream credit counter for one output port.
//               Decrements on any credit_decre bit, increments on a returned
//               credit, holds at 0 and at CREDIT_MAX instead of wrapping.
//               With OUTPUT_UNIT_CREDIT_CHECK_EN defined it also keeps sticky
//               {overflow, underflow} error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_unit_credit_counter
    import output_unit_pkg::*;
#(
    parameter int CREDIT_MAX = c_credit_max,
    parameter int CNT_W      = cnt_width(CREDIT_MAX),
    parameter int DIR_W      = 5
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [DIR_W-1:0] i_decre,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
`ifdef OUTPUT_UNIT_CREDIT_CHECK_EN
    ,
    output logic [1:0]       o_err
`endif
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(CREDIT_MAX);

    logic [CNT_W-1:0] r_cnt;
    logic             w_dec;
    logic             w_at_zero;
    logic             w_at_max;

    // Several input units claiming the same slot still consume only one.
    assign w_dec     = |i_decre;
    assign w_at_zero = (r_cnt == '0);
    assign w_at_max  = (r_cnt == c_max);
    assign o_cnt     = r_cnt;

    // Saturating up/down count; simultaneous take and return cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= c_max;
        end else if (i_en) begin
            case ({w_dec, i_inc})
                2'b10: if (!w_at_zero) r_cnt <= r_cnt - CNT_W'(1);
                2'b01: if (!w_at_max)  r_cnt <= r_cnt + CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef OUTPUT_UNIT_CREDIT_CHECK_EN
    logic [1:0] r_err;
    logic       w_multi;

    // More than one decrement bit in a cycle is a protocol violation.
    assign w_multi = ((i_decre & (i_decre - DIR_W'(1))) != '0);
    assign o_err   = r_err;

    // Sticky error capture: bit1 overflow, bit0 underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 2'b00;
        end else if (i_en) begin
            if ((w_dec && !i_inc && w_at_zero) || w_multi) begin
                r_err[0] <= 1'b1;
            end
            if (i_inc && !w_dec && w_at_max) begin
                r_err[1] <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/output_unit.sv
// ============================================================================
// Module      : output_unit
// Description : Router output port. Registers the crossbar flit toward the
//               downstream router (one cycle latency) and tracks downstream
//               buffer credits, advertising credit_avail to the input units.
//               A one-cycle INIT link state follows every reset.
//               Optional: define OUTPUT_UNIT_CREDIT_CHECK_EN to add the sticky
//               credit_err {overflow, underflow} output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 32
`endif
`ifndef DIRECTION
`define DIRECTION 5
`endif

module output_unit
    import output_unit_pkg::*;
#(
    parameter int CREDIT_MAX = c_credit_max,
    parameter int CNT_W      = cnt_width(CREDIT_MAX)
)(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    input  logic [`ROUTER_WIDTH-1:0] st_data,
    input  logic [`DIRECTION-1:0]    credit_decre,
    input  logic                     credit_in,
    output logic                     credit_avail,
    output logic                     out_data_valid,
    output logic [`ROUTER_WIDTH-1:0] out_data
`ifdef OUTPUT_UNIT_CREDIT_CHECK_EN
    ,
    output logic [1:0]               credit_err
`endif
);

    link_state_t              r_state;
    logic                     w_run;
    logic [CNT_W-1:0]         w_cnt;
    logic                     r_out_valid;
    logic [`ROUTER_WIDTH-1:0] r_out_data;

    assign w_run = (r_state == c_st_run);

    // Link state: INIT for exactly one cycle after reset, then RUN until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_init;
        end else if (r_state == c_st_init) begin
            r_state <= c_st_run;
        end
    end

    // Output stage: valid follows st_valid, data only updates on a valid flit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= st_valid;
            if (st_valid) begin
                r_out_data <= st_data;
            end
        end
    end

    assign out_data_valid = r_out_valid;
    assign out_data       = r_out_data;

    // Credits are only advertised once the link is running.
    assign credit_avail = w_run && (w_cnt != '0);

    output_unit_credit_counter #(
        .CREDIT_MAX (CREDIT_MAX),
        .CNT_W      (CNT_W),
        .DIR_W      (`DIRECTION)
    ) u_credit_counter (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_run),
        .i_decre (credit_decre),
        .i_inc   (credit_in),
        .o_cnt   (w_cnt)
`ifdef OUTPUT_UNIT_CREDIT_CHECK_EN
        ,
        .o_err   (credit_err)
`endif
    );

endmodule

`default_nettype wire

// File: tb/tb_output_unit.sv
// ============================================================================
// Module      : tb_output_unit
// Description : Scoreboard bench for output_unit (CREDIT_MAX = 8, 32-bit
//               flits, 5 directions). The driver pushes the hand-computed
//               post-edge state for every vector; a negedge monitor pops and
//               compares. Define OUTPUT_UNIT_CREDIT_CHECK_EN to also check
//               credit_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_output_unit;

    localparam int W  = 32;
    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          st_valid;
    logic [W-1:0]  st_data;
    logic [DW-1:0] credit_decre;
    logic          credit_in;
    logic          credit_avail;
    logic          out_data_valid;
    logic [W-1:0]  out_data;
`ifdef OUTPUT_UNIT_CREDIT_CHECK_EN
    logic [1:0]    credit_err;
`endif

    always #5 clk = ~clk;

    output_unit #(
        .CREDIT_MAX (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .st_valid       (st_valid),
        .st_data        (st_data),
        .credit_decre   (credit_decre),
        .credit_in      (credit_in),
        .credit_avail   (credit_avail),
        .out_data_valid (out_data_valid),
        .out_data       (out_data)
`ifdef OUTPUT_UNIT_CREDIT_CHECK_EN
        ,
        .credit_err     (credit_err)
`endif
    );

    typedef struct {
        int           tgt;
        logic         v;
        logic [W-1:0] d;
        logic         av;
        logic [3:0]   cnt;
        logic [1:0]   err;
    } exp_t;

    exp_t q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Count rising edges so each expectation knows which edge it belongs to.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare DUT state against the expectation queued for this edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].tgt <= cyc) begin
            e = q.pop_front();
            if (e.tgt != cyc) chk("expectation_edge", 32'(cyc), 32'(e.tgt));
            chk("out_data_valid", 32'(out_data_valid), 32'(e.v));
            chk("out_data",       out_data,            e.d);
            chk("credit_avail",   32'(credit_avail),   32'(e.av));
            chk("cnt",            32'(dut.w_cnt),      32'(e.cnt));
`ifdef OUTPUT_UNIT_CREDIT_CHECK_EN
            chk("credit_err",     32'(credit_err),     32'(e.err));
`endif
        end
    end

    // Apply one vector after a rising edge and queue the state expected
    // after the next rising edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                        input logic [DW-1:0] dec, input logic ci,
                        input logic ev, input logic [W-1:0] ed, input logic eav,
                        input logic [3:0] ecnt, input logic [1:0] eerr);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        st_valid     = v;
        st_data      = d;
        credit_decre = dec;
        credit_in    = ci;
        e.tgt = cyc + 1;
        e.v   = ev;
        e.d   = ed;
        e.av  = eav;
        e.cnt = ecnt;
        e.err = eerr;
        q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        st_valid     = 1'b0;
        st_data      = '0;
        credit_decre = '0;
        credit_in    = 1'b0;

        //   rst v  data          decre     ci   ev  exp data      av cnt err
        // Reset; the second vector's state is observed in the INIT cycle.
        step(1, 0, 32'h0,        5'b00000, 0,   0, 32'h0,        0, 8, 2'b00);
        step(1, 0, 32'h0,        5'b00000, 0,   0, 32'h0,        0, 8, 2'b00);
        // INIT cycle: decrement must be ignored, RUN afterwards.
        step(0, 0, 32'h0,        5'b00001, 0,   0, 32'h0,        1, 8, 2'b00);
        // Flit A5 plus eight single decrements down to zero.
        step(0, 1, 32'h0000_00A5, 5'b00001, 0,  1, 32'h0000_00A5, 1, 7, 2'b00);
        step(0, 0, 32'hFFFF_FFFF, 5'b00010, 0,  0, 32'h0000_00A5, 1, 6, 2'b00);
        step(0, 0, 32'h0,        5'b00100, 0,   0, 32'h0000_00A5, 1, 5, 2'b00);
        step(0, 0, 32'h0,        5'b01000, 0,   0, 32'h0000_00A5, 1, 4, 2'b00);
        step(0, 0, 32'h0,        5'b10000, 0,   0, 32'h0000_00A5, 1, 3, 2'b00);
        step(0, 0, 32'h0,        5'b00001, 0,   0, 32'h0000_00A5, 1, 2, 2'b00);
        step(0, 0, 32'h0,        5'b00010, 0,   0, 32'h0000_00A5, 1, 1, 2'b00);
        step(0, 0, 32'h0,        5'b00100, 0,   0, 32'h0000_00A5, 0, 0, 2'b00);
        // Ninth decrement: underflow, holds at zero.
        step(0, 0, 32'h0,        5'b01000, 0,   0, 32'h0000_00A5, 0, 0, 2'b01);
        // Three credits return.
        step(0, 0, 32'h0,        5'b00000, 1,   0, 32'h0000_00A5, 1, 1, 2'b01);
        step(0, 0, 32'h0,        5'b00000, 1,   0, 32'h0000_00A5, 1, 2, 2'b01);
        step(0, 0, 32'h0,        5'b00000, 1,   0, 32'h0000_00A5, 1, 3, 2'b01);
        // Simultaneous decrement and return cancel.
        step(0, 0, 32'h0,        5'b00100, 1,   0, 32'h0000_00A5, 1, 3, 2'b01);
        // Two decrement bits count once.
        step(0, 0, 32'h0,        5'b00011, 0,   0, 32'h0000_00A5, 1, 2, 2'b01);
        // Reset clears data, flags and refills credits.
        step(1, 0, 32'h0,        5'b00000, 0,   0, 32'h0,        0, 8, 2'b00);
        // INIT cycle: returned credit ignored.
        step(0, 0, 32'h0,        5'b00000, 1,   0, 32'h0,        1, 8, 2'b00);
        // Overflow at CREDIT_MAX holds.
        step(0, 0, 32'h0,        5'b00000, 1,   0, 32'h0,        1, 8, 2'b10);
        // Multi-bit decrement flags underflow, still one decrement.
        step(0, 0, 32'h0,        5'b10001, 0,   0, 32'h0,        1, 7, 2'b11);
        // Flit 3C, then reset with an in-flight flit and pending credit.
        step(0, 1, 32'h0000_003C, 5'b00000, 0,  1, 32'h0000_003C, 1, 7, 2'b11);
        step(1, 1, 32'h0000_0077, 5'b00001, 1,  0, 32'h0,        0, 8, 2'b00);
        step(0, 0, 32'h0,        5'b00000, 0,   0, 32'h0,        1, 8, 2'b00);
        // Normal traffic after recovery.
        step(0, 1, 32'h0000_005A, 5'b00010, 0,  1, 32'h0000_005A, 1, 7, 2'b00);
        step(0, 0, 32'h0,        5'b00000, 0,   0, 32'h0000_005A, 1, 7, 2'b00);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/output_unit.md
OUTPUT_UNIT -- requirements
Module: output_unit

Interface
REQ-001 Parameter CREDIT_MAX, default `ROUTER_FIFO_DEPTH*`ROUTER_FIFO_SPLIT: downstream input-buffer slots for this port.
REQ-002 Parameter CNT_W, default $clog2(CREDIT_MAX+1): credit counter width.
REQ-003 clk  input  1  system clock; the block uses one clock.
REQ-004 rst  input  1  system reset; synchronous, active-high.
REQ-005 st_valid  input  1  crossbar delivers a flit to this output port this cycle.
REQ-006 st_data  input  `ROUTER_WIDTH  crossbar flit.
REQ-007 credit_decre  input  `DIRECTION  per-input-unit credit decrement for this port; at most one bit set per cycle.
REQ-008 credit_in  input  1  credit return pulse from the downstream router, one slot freed.
REQ-009 credit_avail  output  1  at least one downstream slot is free; fans out to every input unit.
REQ-010 out_data_valid  output  1  flit valid toward the downstream router.
REQ-011 out_data  output  `ROUTER_WIDTH  flit toward the downstream router.
REQ-012 credit_err  output  2  sticky {overflow, underflow} flags; present only with the REQ-027 macro.

Function
REQ-013 Output stage: out_data_valid <= st_valid and out_data <= st_data, one cycle latency, registered every cycle.
REQ-014 When st_valid=0, out_data holds its previous value; only out_data_valid drops.
REQ-015 Credit counter cnt[CNT_W-1:0]: dec = |credit_decre, inc = credit_in.
REQ-016 dec=1, inc=0: cnt <= cnt-1 next cycle.
REQ-017 dec=0, inc=1: cnt <= cnt+1 next cycle.
REQ-018 dec=1, inc=1 in the same cycle: cnt is unchanged.
REQ-019 dec=1 with cnt=0 (underflow): cnt holds 0, no wrap.
REQ-020 inc=1 with cnt=CREDIT_MAX (overflow): cnt holds CREDIT_MAX, no wrap.
REQ-021 credit_avail = (cnt != 0), combinational from the register; a decrement in cycle N is reflected in credit_avail in cycle N+1.
REQ-022 Link state machine, states INIT and RUN.
- Reset enters INIT.
- INIT drives credit_avail=0 and ignores dec/inc for exactly one cycle, then moves to RUN.
- RUN is permanent until the next reset.
REQ-023 More than one credit_decre bit set in one cycle counts as a single decrement; with the macro it also sets the underflow flag.

Reset
REQ-024 While rst=1, out_data_valid=0, out_data=0, cnt=CREDIT_MAX, state=INIT, credit_err=2'b00.
REQ-025 Reset asserted mid-operation discards any in-flight flit: out_data_valid is 0 on the following cycle and any pending credit is lost.
REQ-026 credit_avail is 0 during reset and during the INIT cycle, and 1 from the first RUN cycle.

Configuration
REQ-027 Macro OUTPUT_UNIT_CREDIT_CHECK_EN.
- Defined: credit_err exists.
- Bit0 (underflow) is set on REQ-019 or REQ-023.
- Bit1 (overflow) is set on REQ-020.
- Both bits are sticky until reset.
REQ-028 Macro undefined: credit_err port and its logic are absent; counter saturation behaviour is unchanged.

Structure
REQ-029 CREDIT_MAX default, CNT_W derivation and the INIT/RUN state encoding are placed in router.vh beside `ROUTER_FIFO_DEPTH.
REQ-030 One sub-module, CreditCounter (cnt, saturation, error flags); the data register and FSM stay in output_unit.

Verification
REQ-031 Reset with CREDIT_MAX=8, release -> credit_avail=0 for one cycle, then 1; cnt=8.
REQ-032 Eight single-bit credit_decre pulses, no credit_in -> cnt 8..0, credit_avail=0 the cycle after the 8th; a 9th pulse keeps cnt=0 and, with the macro, sets credit_err=2'b01.
REQ-033 cnt=3, credit_decre=5'b00100 and credit_in=1 in the same cycle -> cnt stays 3, credit_avail stays 1.
REQ-034 st_valid=1 with st_data=0xA5 for one cycle -> out_data_valid=1, out_data=0xA5 exactly one cycle later, then out_data_valid=0 with out_data still 0xA5.
REQ-035 cnt=8, credit_in=1 -> cnt stays 8 and, with the macro, credit_err=2'b10; rst pulse -> 2'b00.
REQ-036 rst asserted in the cycle after st_valid=1 -> out_data_valid=0 and cnt=8 on the next cycle.
